mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   CPU-side controller for the 256x16 data RAM wrapper (ram_md). Accepts
//   single read/write requests from the CPU over a ready/valid handshake and
//   sequences the synchronous RAM port (we/addr/D_in/D_out). It absorbs the
//   RAM's registered read latency. After reset it can zero-fill every RAM word
//   before the CPU is allowed any access.
// PARAMETERS
//   AW             8   address width; RAM depth = 2**AW
//   DW             16  data width
//   RD_LAT         1   RAM read latency in cycles (address edge -> D_out valid), >=1
//   CLEAR_ON_RESET 1   1: zero-fill RAM after reset; 0: go straight to IDLE
// PORTS
//   clk         in   1   system clock; all logic rising-edge
//   rst         in   1   asynchronous, active-high reset
//   cpu_req     in   1   CPU request; sampled only while cpu_ready=1
//   cpu_we      in   1   1=write, 0=read; sampled with cpu_req
//   cpu_addr    in   AW  request address
//   cpu_wdata   in   DW  write data
//   cpu_ready   out  1   controller idle, request accepted this edge if cpu_req
//   cpu_rvalid  out  1   one-cycle pulse, cpu_rdata valid
//   cpu_rdata   out  DW  read data, held until next read completes
//   cpu_wdone   out  1   one-cycle pulse, write issued to RAM
//   init_busy   out  1   zero-fill in progress
//   ram_we      out  1   to ram_md we
//   ram_addr    out  AW  to ram_md addr
//   ram_din     out  DW  to ram_md D_in
//   ram_dout    in   DW  from ram_md D_out
// BEHAVIOUR
//   - All outputs registered except cpu_ready=(state==IDLE), init_busy=(state==INIT).
//   - Reset: state=INIT (CLEAR_ON_RESET=1) else IDLE; ram_we=0, ram_addr=0,
//     ram_din=0, cpu_rdata=0, cpu_rvalid=0, cpu_wdone=0, wait counter=0.
//   - States: INIT, IDLE, WRITE, READ, RD_WAIT.
//   - INIT: first edge after rst release sets ram_we=1, ram_addr=0, ram_din=0;
//     each later edge ram_addr+1. Edge with ram_addr==2**AW-1 and ram_we=1:
//     ram_we<=0, state<=IDLE. Exactly 2**AW write cycles; no wrap to 0.
//     CPU requests ignored throughout (cpu_ready=0).
//   - IDLE: accept edge = cpu_req&&cpu_ready. Latch cpu_we/addr/wdata; CPU
//     inputs may change afterwards. No queuing; requests not accepted are dropped.
//   - Write: accept edge -> WRITE cycle: ram_we=1, ram_addr=A, ram_din=D,
//     cpu_wdone=1; next edge ram_we<=0, state<=IDLE. Write every 2 cycles max.
//   - Read: accept edge -> READ cycle: ram_addr=A, ram_we=0; then RD_WAIT for
//     RD_LAT cycles; on final RD_WAIT edge cpu_rdata<=ram_dout, cpu_rvalid<=1,
//     state<=IDLE. cpu_rvalid high in cycle (2+RD_LAT) after the accept edge.
//     cpu_ready rises in the same cycle as cpu_rvalid.
//   - ram_addr holds last value when idle; ram_we only high in INIT/WRITE.
//   - cpu_rvalid/cpu_wdone never high together; never high in INIT.
//   - Reset mid-operation: in-flight access aborted, no pulse emitted, ram_we
//     drops immediately (async), zero-fill restarts from address 0.
// TESTING
//   1. Reset release, CLEAR_ON_RESET=1 -> ram_we high 256 cycles, addr 0..255,
//      din 0; init_busy falls and cpu_ready rises on cycle 257; RAM all zero.
//   2. Write A=0x3C D=0xBEEF -> one-cycle ram_we, ram_addr=0x3C, ram_din=0xBEEF,
//      cpu_wdone pulse; then read 0x3C -> cpu_rvalid 3 cycles after accept,
//      cpu_rdata=0xBEEF.
//   3. Back-to-back: req held high, write 0x00=0x1234, read 0x00, write
//      0xFF=0xA5A5, read 0xFF -> 0x1234, 0xA5A5; req ignored while ready=0.
//   4. cpu_req pulsed during INIT and during RD_WAIT -> no RAM access, no pulse,
//      cpu_rdata unchanged.
//   5. rst asserted in READ and at INIT address 0x80 -> ram_we=0 at once,
//      no cpu_rvalid; sweep restarts at 0x00 after release.
//   6. RD_LAT=2, CLEAR_ON_RESET=0 -> ready=1 right after reset; read of
//      preloaded 0x10 returns valid data 4 cycles after accept.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU-side sequencer for a synchronous single-port RAM.
// Takes single read/write requests over a ready/valid handshake, drives the
// RAM port, hides the RAM's registered read latency, and can zero-fill the
// whole RAM after reset before the CPU is let in.
module mem_access_ctrl #(
    parameter int AW             = 8,
    parameter int DW             = 16,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_wdone,
    output logic          init_busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int            CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RD_WAIT
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_INIT : S_IDLE;

    state_t          state_q, state_d;
    logic            ram_we_q, ram_we_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_din_q, ram_din_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            wdone_q, wdone_d;
    logic [CW-1:0]   wait_q, wait_d;

    // The sweep ends on the edge that sees the last address being written.
    logic init_last;
    assign init_last = ram_we_q && (ram_addr_q == ADDR_MAX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RST_STATE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    if (init_last) state_d = S_IDLE;
            S_IDLE:    if (cpu_req) state_d = cpu_we ? S_WRITE : S_READ;
            S_WRITE:   state_d = S_IDLE;
            S_READ:    state_d = S_RD_WAIT;
            S_RD_WAIT: if (wait_q == '0) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; RAM port registers double as the request latch
    always_comb begin
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        wdone_d    = 1'b0;
        wait_d     = wait_q;
        case (state_q)
            S_INIT: begin
                if (!init_last) begin
                    ram_we_d  = 1'b1;
                    ram_din_d = '0;
                    // First sweep edge writes address 0, later edges step up.
                    if (ram_we_q) ram_addr_d = ram_addr_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (cpu_req) begin
                    ram_addr_d = cpu_addr;
                    if (cpu_we) begin
                        ram_we_d  = 1'b1;
                        ram_din_d = cpu_wdata;
                        wdone_d   = 1'b1;
                    end
                end
            end
            S_READ: begin
                wait_d = CW'(RD_LAT - 1);
            end
            S_RD_WAIT: begin
                if (wait_q == '0) begin
                    rdata_d  = ram_dout;
                    rvalid_d = 1'b1;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs; reset drops ram_we immediately and kills any pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wdone_q    <= 1'b0;
            wait_q     <= '0;
        end else begin
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            wdone_q    <= wdone_d;
            wait_q     <= wait_d;
        end
    end

    assign cpu_ready  = (state_q == S_IDLE);
    assign init_busy  = (state_q == S_INIT);
    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rdata_q;
    assign cpu_wdone  = wdone_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl.
// DUT 1: default parameters (RD_LAT=1, zero-fill). DUT 2: RD_LAT=2, no zero-fill.
module tb_mem_access_ctrl;

    localparam int RD_LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1 ----------------
    logic        rst, cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready, cpu_rvalid, cpu_wdone, init_busy, ram_we;
    logic [15:0] cpu_rdata, ram_din, ram_dout;
    logic [7:0]  ram_addr;
    logic [15:0] ram [256];

    mem_access_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_wdone(cpu_wdone),
        .init_busy(init_busy), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // RAM with one cycle registered read
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    // ---------------- DUT 2 ----------------
    logic        rst2, req2, we2;
    logic [7:0]  addr2;
    logic [15:0] wdata2;
    logic        ready2, rvalid2, wdone2, busy2, ram2_we;
    logic [15:0] rdata2, ram2_din, ram2_dout, ram2_p1;
    logic [7:0]  ram2_addr;
    logic [15:0] ram2 [256];
    logic [15:0] ref2 [256];

    mem_access_ctrl #(.RD_LAT(2), .CLEAR_ON_RESET(0)) dut2 (
        .clk(clk), .rst(rst2), .cpu_req(req2), .cpu_we(we2),
        .cpu_addr(addr2), .cpu_wdata(wdata2), .cpu_ready(ready2),
        .cpu_rvalid(rvalid2), .cpu_rdata(rdata2), .cpu_wdone(wdone2),
        .init_busy(busy2), .ram_we(ram2_we), .ram_addr(ram2_addr),
        .ram_din(ram2_din), .ram_dout(ram2_dout)
    );

    // RAM with two cycle registered read
    always @(posedge clk) begin
        if (ram2_we) ram2[ram2_addr] <= ram2_din;
        ram2_p1   <= ram2[ram2_addr];
        ram2_dout <= ram2_p1;
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [15:0] data;
        int          due;   // edge count after which the pulse is visible
    } exp_t;

    exp_t        sbq [$];
    exp_t        mon_e;
    logic [15:0] ref_mem [256];
    logic [15:0] last_rdata;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever DUT 1 emits a completion pulse
    always @(negedge clk) begin
        if (mon_en) begin
            if (cpu_rvalid && cpu_wdone) chk("pulse_overlap", 1, 0);
            if (cpu_wdone || cpu_rvalid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("pulse_kind", {31'd0, cpu_wdone}, {31'd0, mon_e.is_wr});
                    chk("latency", cyc, mon_e.due);
                    if (mon_e.is_wr) begin
                        chk("wr_we", {31'd0, ram_we}, 1);
                        chk("wr_addr", {24'd0, ram_addr}, {24'd0, mon_e.addr});
                        chk("wr_din", {16'd0, ram_din}, {16'd0, mon_e.data});
                    end else begin
                        chk("rd_data", {16'd0, cpu_rdata}, {16'd0, mon_e.data});
                        last_rdata = mon_e.data;
                    end
                end
            end else begin
                if (sbq.size() > 0 && sbq[0].due < cyc) begin
                    chk("missing_pulse", 0, 1);
                    void'(sbq.pop_front());
                end
                chk("rdata_hold", {16'd0, cpu_rdata}, {16'd0, last_rdata});
                chk("ram_we_idle", {31'd0, ram_we}, 0);
            end
        end
    end

    task automatic junk();
        cpu_req   = 1'($urandom);
        cpu_we    = 1'($urandom);
        cpu_addr  = 8'($urandom);
        cpu_wdata = 16'($urandom);
    endtask

    // Wait for ready (driving ignored junk meanwhile), then present one request
    task automatic issue(input bit we, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        int   n = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready) break;
            junk();
            n++;
            if (n > 50) begin
                chk("ready_timeout", 0, 1);
                return;
            end
        end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        e.is_wr = we;
        e.addr  = a;
        if (we) begin
            e.data     = d;
            e.due      = cyc + 1;
            ref_mem[a] = d;
        end else begin
            e.data = ref_mem[a];
            e.due  = cyc + 2 + RD_LAT;
        end
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cpu_req = 1'b0;
        end
    endtask

    // Called at the negedge where rst was just released: checks the full sweep
    task automatic init_check();
        int nz = 0;
        for (int k = 0; k <= 257; k++) begin
            chk("init_we", {31'd0, ram_we}, (k >= 1 && k <= 256) ? 1 : 0);
            chk("init_addr", {24'd0, ram_addr}, (k == 0) ? 0 : ((k > 256) ? 255 : k - 1));
            chk("init_busy", {31'd0, init_busy}, (k <= 256) ? 1 : 0);
            chk("init_ready", {31'd0, cpu_ready}, (k >= 257) ? 1 : 0);
            if (ram_we) chk("init_din", {16'd0, ram_din}, 0);
            if (cpu_rvalid || cpu_wdone) chk("init_pulse", 1, 0);
            if (k < 257) begin
                @(negedge clk);
                junk();
            end
        end
        cpu_req = 1'b0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 16'h0) nz++;
        chk("ram_zeroed", nz, 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0;
        last_rdata = 16'h0;
    endtask

    task automatic random_ops(input int n);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            issue(1'($urandom), a, 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(8);
        chk("sb_drained", sbq.size(), 0);
    endtask

    // DUT 2 single operation with its own bounded completion wait
    task automatic op2(input bit we, input logic [7:0] a, input logic [15:0] d, input int lat);
        int acc;
        bit seen = 1'b0;
        @(negedge clk);
        chk("d2_ready", {31'd0, ready2}, 1);
        req2 = 1'b1; we2 = we; addr2 = a; wdata2 = d;
        acc = cyc + 1;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            req2 = 1'b0;
            if (we ? wdone2 : rvalid2) begin
                seen = 1'b1;
                chk("d2_latency", cyc - acc, lat);
                if (we) begin
                    chk("d2_wr_addr", {24'd0, ram2_addr}, {24'd0, a});
                    chk("d2_wr_din", {16'd0, ram2_din}, {16'd0, d});
                end else begin
                    chk("d2_rdata", {16'd0, rdata2}, {16'd0, ref2[a]});
                end
            end
        end
        if (!seen) chk("d2_timeout", 0, 1);
        if (we) ref2[a] = d;
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        rst2 = 1'b1; req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i]  = 16'($urandom) | 16'h1;
            ram2[i] = 16'($urandom);
            ref2[i] = ram2[i];
        end
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_we", {31'd0, ram_we}, 0);
        chk("rst_addr", {24'd0, ram_addr}, 0);
        chk("rst_din", {16'd0, ram_din}, 0);
        chk("rst_rdata", {16'd0, cpu_rdata}, 0);
        chk("rst_rvalid", {31'd0, cpu_rvalid}, 0);
        chk("rst_wdone", {31'd0, cpu_wdone}, 0);
        chk("rst_busy", {31'd0, init_busy}, 1);
        chk("rst_ready", {31'd0, cpu_ready}, 0);

        // Zero-fill sweep with requests ignored
        rst = 1'b0;
        init_check();
        mon_en = 1'b1;

        // Directed write/read and back-to-back boundaries
        issue(1'b1, 8'h3C, 16'hBEEF);
        idle(2);
        issue(1'b0, 8'h3C, 16'h0);
        idle(4);
        issue(1'b1, 8'h00, 16'h1234);
        issue(1'b0, 8'h00, 16'h0);
        issue(1'b1, 8'hFF, 16'hA5A5);
        issue(1'b0, 8'hFF, 16'h0);
        random_ops(150);

        // Reset during READ: no pulse, ram_we low, sweep restarts
        issue(1'b0, 8'h3C, 16'h0);
        @(posedge clk);
        #2;
        cpu_req = 1'b0;
        mon_en  = 1'b0;
        sbq.delete();
        rst = 1'b1;
        #1;
        chk("rdrst_we", {31'd0, ram_we}, 0);
        chk("rdrst_rvalid", {31'd0, cpu_rvalid}, 0);
        chk("rdrst_busy", {31'd0, init_busy}, 1);
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom) | 16'h1;
        @(negedge clk);
        rst = 1'b0;
        init_check();

        // Reset mid-sweep at address 0x80: ram_we drops asynchronously
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (129) @(posedge clk);
        #2;
        chk("sweep_pre_addr", {24'd0, ram_addr}, 8'h80);
        chk("sweep_pre_we", {31'd0, ram_we}, 1);
        rst = 1'b1;
        #1;
        chk("sweep_rst_we", {31'd0, ram_we}, 0);
        chk("sweep_rst_addr", {24'd0, ram_addr}, 0);
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom) | 16'h1;
        @(negedge clk);
        rst = 1'b0;
        init_check();
        mon_en = 1'b1;
        random_ops(40);

        // DUT 2: no sweep, ready straight out of reset, two-cycle RAM
        chk("d2_rst_ready", {31'd0, ready2}, 1);
        chk("d2_rst_busy", {31'd0, busy2}, 0);
        rst2 = 1'b0;
        @(negedge clk);
        chk("d2_ready_after_rst", {31'd0, ready2}, 1);
        chk("d2_we_idle", {31'd0, ram2_we}, 0);
        op2(1'b0, 8'h10, 16'h0, 3);
        op2(1'b1, 8'h22, 16'($urandom), 0);
        op2(1'b0, 8'h22, 16'h0, 3);
        op2(1'b0, 8'h10, 16'h0, 3);

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
